cpu_bus_bridge: RTL and testbench
=================================

# cpu_bus_bridge

Memory-side bus bridge sitting directly downstream of the `Cpu` core. It accepts the core's `req_rdwr` / `which_rdwr` / `addr` / `data_out` requests and runs each one against a strobe/acknowledge memory port. It inserts programmable wait states and applies a bus timeout. While a transfer is in flight it stalls the core through the core's `enable` input, and on completion it returns read data on the core's `data_in`.

## Interface
- `ADDR_WIDTH`, 16, CPU/memory address width (16-bit space for now).
- `DATA_WIDTH`, 8, data byte width.
- `WAIT_STATES`, 2, setup cycles between accept and strobe; legal range 0..15.
- `TIMEOUT`, 16, max strobe cycles awaiting `mem_ack`; legal range 1..255.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_rdwr`  in  1  CPU request strobe.
- `which_rdwr`  in  1  0 = read (`ENUM__CPU_WH_RDWR__READ`), 1 = write (`ENUM__CPU_WH_RDWR__WRITE`).
- `addr`  in  ADDR_WIDTH  CPU address.
- `cpu_wdata`  in  DATA_WIDTH  CPU `data_out`.
- `cpu_rdata`  out  DATA_WIDTH  drives CPU `data_in`; registered.
- `cpu_enable`  out  1  drives CPU `enable`; registered; low = CPU stalled.
- `mem_cs`  out  1  memory strobe; registered.
- `mem_we`  out  1  memory write enable; valid while `mem_cs` = 1.
- `mem_addr`  out  ADDR_WIDTH  latched address.
- `mem_wdata`  out  DATA_WIDTH  latched write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; sampled on the edge where `mem_ack` = 1.
- `mem_ack`  in  1  memory acknowledge; only meaningful while `mem_cs` = 1.
- `err_clr`  in  1  clears `bus_err`.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - `cpu_enable` = 1.
  - On an edge with `req_rdwr` = 1, latch `addr`→`mem_addr`, `cpu_wdata`→`mem_wdata`, and `which_rdwr`.
  - Drive `cpu_enable` to 0 on the same edge.
  - Next state is SETUP with the wait counter loaded to `WAIT_STATES`, or STROBE when `WAIT_STATES` = 0.
- SETUP: decrement the wait counter each cycle. When it reaches 1, go to STROBE. Registered `mem_cs` ← 1 and `mem_we` ← latched `which_rdwr` on that edge.
- STROBE:
  - `mem_cs` stays high and `mem_addr` / `mem_wdata` / `mem_we` are held stable.
  - The timeout counter increments each cycle.
  - On an edge with `mem_ack` = 1: go to DONE, clear `mem_cs` and `mem_we`, set `cpu_enable` ← 1. For a read, set `cpu_rdata` ← `mem_rdata`.
  - If the counter reaches `TIMEOUT` with no ack, take the same actions but set `bus_err` ← 1. For a read, set `cpu_rdata` ← all ones.
- DONE: one cycle, `cpu_enable` = 1. `req_rdwr` is ignored here because the CPU is updating it on this edge. Next state is IDLE.
- A write never changes `cpu_rdata`. `cpu_rdata` holds the last completed read value until the next read completes.
- `bus_err` is sticky and cleared by `err_clr`. If a timeout and `err_clr` occur on the same edge, the set wins.
- If `mem_ack` arrives on the same edge the timeout would fire, the ack wins: it is a normal completion with no error.
- A `mem_ack` outside STROBE is ignored.
- Counters are unsigned: 4-bit wait counter, 8-bit timeout counter. Neither wraps, because the FSM leaves the state first.

## Timing
- Reset values (asynchronous, applied immediately): state IDLE, `cpu_enable` = 1, `cpu_rdata` = 0, `mem_cs` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `bus_err` = 0, both counters 0.
- Reset mid-transfer aborts it and drops `mem_cs` without waiting for a clock.
- Cycle-level latency, with E0 as the accept edge:
  - `mem_cs` rises after edge E0 + `WAIT_STATES`.
  - With an ack k cycles into strobe (k ≥ 1), `cpu_enable` is low for exactly `WAIT_STATES` + k cycles.
  - `cpu_rdata` is valid in the first cycle that `cpu_enable` is high again.
- Minimum transfer (`WAIT_STATES` = 0, ack in the first strobe cycle): `cpu_enable` is low for 1 cycle.
- Back-to-back requests: the earliest new accept is the edge after DONE, so there is at least one DONE cycle plus one IDLE cycle between strobes.
- On timeout, `cpu_enable` is low for `WAIT_STATES` + `TIMEOUT` cycles.

## Test plan
- Reset mid-strobe: assert `rst` asynchronously → `mem_cs` and `mem_we` drop before the next edge; `cpu_enable` = 1; `cpu_rdata` = 0; state IDLE; `bus_err` = 0.
- Read with `WAIT_STATES` = 2, `addr` = 16'h2329, ack in the 1st strobe cycle with `mem_rdata` = 8'hA5:
  - `mem_cs` rises 2 cycles after accept; `mem_we` = 0.
  - `cpu_enable` is low for 3 cycles; `cpu_rdata` = 8'hA5.
- Write with `WAIT_STATES` = 0, `addr` = 16'h9001, `cpu_wdata` = 8'h3C, ack after 3 strobe cycles:
  - `mem_we` = 1 and `mem_wdata` = 8'h3C are held throughout.
  - `cpu_enable` is low for 3 cycles; `cpu_rdata` is unchanged.
- Read with no ack and `TIMEOUT` = 16: after 16 strobe cycles, `bus_err` = 1, `cpu_rdata` = 8'hFF, `cpu_enable` = 1. Then pulse `err_clr` → `bus_err` = 0.
- Ack on the exact timeout cycle → normal completion, `bus_err` stays 0. Separately, timeout together with `err_clr` on the same edge → `bus_err` = 1.
- Stale `req_rdwr` held at 1 through DONE → no second transfer is accepted until the edge after DONE. A stray `mem_ack` in IDLE → no state change.

Source files
------------

// File: rtl/cpu_bus_bridge.sv
// Memory-side bridge for the Cpu core: runs each CPU request against a strobe/ack
// memory port with programmable wait states, a bus timeout and a CPU stall.
module cpu_bus_bridge #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_rdwr,
   input  logic                  which_rdwr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_enable,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   input  logic                  err_clr,
   output logic                  bus_err
);
   localparam int unsigned WAIT_W  = 4;
   localparam int unsigned TO_W    = 8;
   localparam logic        WH_READ = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_DONE
   } state_t;

   state_t              state, state_d;
   logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
   logic [TO_W-1:0]     to_cnt, to_cnt_d;
   logic                which_lat, which_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_d;
   logic                cpu_enable_d;
   logic                mem_cs_d;
   logic                mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_d;
   logic                bus_err_d;

   // State and every output are registered; reset drops the strobe immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         to_cnt     <= '0;
         which_lat  <= 1'b0;
         cpu_rdata  <= '0;
         cpu_enable <= 1'b1;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_d;
         wait_cnt   <= wait_cnt_d;
         to_cnt     <= to_cnt_d;
         which_lat  <= which_d;
         cpu_rdata  <= cpu_rdata_d;
         cpu_enable <= cpu_enable_d;
         mem_cs     <= mem_cs_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         bus_err    <= bus_err_d;
      end
   end

   // Next-state and next-output logic; a timeout set overrides a same-edge clear.
   always_comb begin
      state_d      = state;
      wait_cnt_d   = wait_cnt;
      to_cnt_d     = to_cnt;
      which_d      = which_lat;
      cpu_rdata_d  = cpu_rdata;
      cpu_enable_d = cpu_enable;
      mem_cs_d     = mem_cs;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      bus_err_d    = err_clr ? 1'b0 : bus_err;

      unique case (state)
         S_IDLE: begin
            cpu_enable_d = 1'b1;
            if (req_rdwr) begin
               mem_addr_d   = addr;
               mem_wdata_d  = cpu_wdata;
               which_d      = which_rdwr;
               cpu_enable_d = 1'b0;
               to_cnt_d     = '0;
               if (WAIT_STATES == 0) begin
                  state_d  = S_STROBE;
                  mem_cs_d = 1'b1;
                  mem_we_d = which_rdwr;
               end else begin
                  state_d    = S_SETUP;
                  wait_cnt_d = WAIT_W'(WAIT_STATES);
               end
            end
         end
         S_SETUP: begin
            if (wait_cnt == WAIT_W'(1)) begin
               state_d    = S_STROBE;
               wait_cnt_d = '0;
               mem_cs_d   = 1'b1;
               mem_we_d   = which_lat;
            end else begin
               wait_cnt_d = wait_cnt - WAIT_W'(1);
            end
         end
         S_STROBE: begin
            if (mem_ack || (to_cnt == TO_W'(TIMEOUT - 1))) begin
               state_d      = S_DONE;
               to_cnt_d     = '0;
               mem_cs_d     = 1'b0;
               mem_we_d     = 1'b0;
               cpu_enable_d = 1'b1;
               if (!mem_ack) begin
                  bus_err_d = 1'b1;
               end
               if (which_lat == WH_READ) begin
                  cpu_rdata_d = mem_ack ? mem_rdata : '1;
               end
            end else begin
               to_cnt_d = to_cnt + TO_W'(1);
            end
         end
         S_DONE: begin
            cpu_enable_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Bench for cpu_bus_bridge: two instances (2 wait states / timeout 16, and
// 0 wait states / timeout 4) checked against a transaction-level model.
module tb_cpu_bus_bridge;
   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 8;
   localparam int unsigned WS_A = 2;
   localparam int unsigned TO_A = 16;
   localparam int unsigned WS_B = 0;
   localparam int unsigned TO_B = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req, which, err_clr, mem_ack, use_b;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, mem_rdata;

   logic          a_req, b_req, a_ack, b_ack, a_clr, b_clr;
   logic [DW-1:0] a_rdata, b_rdata, a_mwdata, b_mwdata;
   logic [AW-1:0] a_maddr, b_maddr;
   logic          a_en, b_en, a_cs, b_cs, a_we, b_we, a_err, b_err;

   logic          en, cs, we, err;
   logic [DW-1:0] rdata, mwdata;
   logic [AW-1:0] maddr;

   logic [DW-1:0] rd_m [2];
   logic          err_m [2];
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   assign a_req = req & ~use_b;
   assign b_req = req & use_b;
   assign a_ack = mem_ack & ~use_b;
   assign b_ack = mem_ack & use_b;
   assign a_clr = err_clr & ~use_b;
   assign b_clr = err_clr & use_b;

   assign en     = use_b ? b_en     : a_en;
   assign cs     = use_b ? b_cs     : a_cs;
   assign we     = use_b ? b_we     : a_we;
   assign err    = use_b ? b_err    : a_err;
   assign rdata  = use_b ? b_rdata  : a_rdata;
   assign mwdata = use_b ? b_mwdata : a_mwdata;
   assign maddr  = use_b ? b_maddr  : a_maddr;

   cpu_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_A), .TIMEOUT(TO_A)) dut_a (
      .clk(clk), .rst(rst), .req_rdwr(a_req), .which_rdwr(which), .addr(addr),
      .cpu_wdata(wdata), .cpu_rdata(a_rdata), .cpu_enable(a_en), .mem_cs(a_cs),
      .mem_we(a_we), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(mem_rdata),
      .mem_ack(a_ack), .err_clr(a_clr), .bus_err(a_err));

   cpu_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_B), .TIMEOUT(TO_B)) dut_b (
      .clk(clk), .rst(rst), .req_rdwr(b_req), .which_rdwr(which), .addr(addr),
      .cpu_wdata(wdata), .cpu_rdata(b_rdata), .cpu_enable(b_en), .mem_cs(b_cs),
      .mem_we(b_we), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(mem_rdata),
      .mem_ack(b_ack), .err_clr(b_clr), .bus_err(b_err));

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 1'b0; which = 1'b0; addr = '0; wdata = '0;
      mem_ack = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rd_m[0] = '0; rd_m[1] = '0; err_m[0] = 1'b0; err_m[1] = 1'b0;
   endtask

   // One transfer on the selected instance; k = strobe cycle carrying the ack (0 = never).
   task automatic run_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int k, input logic [DW-1:0] rdv, input bit clr_at_to);
      int ws, to, n, low, sidx, cs_first, sel, exp_low;
      bit stable_ok, done, timed_out, clr_hit;
      sel = use_b ? 1 : 0;
      ws  = use_b ? int'(WS_B) : int'(WS_A);
      to  = use_b ? int'(TO_B) : int'(TO_A);
      timed_out = (k == 0) || (k > to);
      clr_hit   = clr_at_to && ((k == 0) || (k >= to));
      exp_low   = ws + (timed_out ? to : k);
      @(negedge clk);
      req = 1'b1; which = wr; addr = a; wdata = d;
      @(posedge clk);
      n = 0; low = 0; sidx = 0; cs_first = -1; stable_ok = 1'b1; done = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk);
         req = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
         if (en === 1'b1) begin
            done = 1'b1;
         end else begin
            low++;
            if (cs === 1'b1) begin
               if (cs_first < 0) cs_first = n;
               if (we !== wr || maddr !== a || mwdata !== d) stable_ok = 1'b0;
               sidx++;
               if (sidx == k) begin
                  mem_ack = 1'b1; mem_rdata = rdv;
               end else begin
                  mem_rdata = DW'($urandom);
               end
               if (clr_at_to && sidx == to) err_clr = 1'b1;
            end
         end
         n++;
      end
      if (!wr) rd_m[sel] = timed_out ? '1 : rdv;
      err_m[sel] = timed_out | (err_m[sel] & ~clr_hit);

      checks++;
      if (!done) begin errors++; $display("FAIL xfer_bound: cpu_enable never returned high after %0d cycles", n); end
      checks++;
      if (low != exp_low) begin errors++; $display("FAIL stall_cycles: got %0d expected %0d (k=%0d)", low, exp_low, k); end
      checks++;
      if (cs_first != ws) begin errors++; $display("FAIL cs_rise: got cycle %0d expected %0d", cs_first, ws); end
      checks++;
      if (!stable_ok) begin errors++; $display("FAIL strobe_hold: mem_we/mem_addr/mem_wdata not held (we=%0b addr=%h wdata=%h)", wr, a, d); end
      checks++;
      if (rdata !== rd_m[sel]) begin errors++; $display("FAIL cpu_rdata: got %h expected %h", rdata, rd_m[sel]); end
      checks++;
      if (err !== err_m[sel]) begin errors++; $display("FAIL bus_err: got %b expected %b", err, err_m[sel]); end
      checks++;
      if (cs !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL strobe_drop: got cs=%b we=%b expected 0 0", cs, we); end
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      int sel;
      sel = use_b ? 1 : 0;
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      err_m[sel] = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got bus_err=%b expected 0", err); end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (a_en !== 1'b1 || b_en !== 1'b1) begin errors++; $display("FAIL reset_enable: got %b %b expected 1 1", a_en, b_en); end
      checks++;
      if (a_cs !== 1'b0 || b_cs !== 1'b0 || a_we !== 1'b0 || b_we !== 1'b0) begin
         errors++; $display("FAIL reset_strobe: got cs=%b%b we=%b%b expected 0", a_cs, b_cs, a_we, b_we);
      end
      checks++;
      if (a_rdata !== '0 || b_rdata !== '0 || a_err !== 1'b0 || b_err !== 1'b0) begin
         errors++; $display("FAIL reset_data: got rdata=%h/%h err=%b/%b expected 0", a_rdata, b_rdata, a_err, b_err);
      end
      checks++;
      if (a_maddr !== '0 || a_mwdata !== '0 || b_maddr !== '0 || b_mwdata !== '0) begin
         errors++; $display("FAIL reset_latch: got addr=%h wdata=%h expected 0", a_maddr, a_mwdata);
      end
   endtask

   task automatic test_read_ws2();
      use_b = 1'b0;
      run_xfer(1'b0, 16'h2329, 8'h00, 1, 8'hA5, 1'b0);
   endtask

   task automatic test_write_ws0();
      use_b = 1'b1;
      run_xfer(1'b1, 16'h9001, 8'h3C, 3, 8'h11, 1'b0);
      run_xfer(1'b0, 16'h0007, 8'h00, 1, 8'h6B, 1'b0);
   endtask

   task automatic test_timeout();
      use_b = 1'b0;
      run_xfer(1'b0, 16'h1000, 8'h00, 0, 8'h00, 1'b0);
      pulse_clr();
      run_xfer(1'b0, 16'h1001, 8'h00, int'(TO_A), 8'h4E, 1'b0);
      run_xfer(1'b0, 16'h1002, 8'h00, 0, 8'h00, 1'b1);
      use_b = 1'b1;
      run_xfer(1'b1, 16'h2002, 8'h99, 0, 8'h00, 1'b1);
   endtask

   task automatic test_back_to_back();
      int n;
      bit done;
      use_b = 1'b0;
      @(negedge clk); req = 1'b1; which = 1'b0; addr = 16'h1234; wdata = 8'h00;
      @(posedge clk);
      n = 0; done = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (en === 1'b1) done = 1'b1;
         else if (cs === 1'b1) begin mem_ack = 1'b1; mem_rdata = 8'h5A; end
         n++;
      end
      checks++;
      if (!done || rdata !== 8'h5A) begin errors++; $display("FAIL stale_first: got rdata=%h done=%0b expected 5a 1", rdata, done); end
      @(negedge clk);
      checks++;
      if (en !== 1'b1 || cs !== 1'b0) begin errors++; $display("FAIL stale_done_ignored: got en=%b cs=%b expected 1 0", en, cs); end
      @(negedge clk);
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL stale_accept: got en=%b expected 0", en); end
      req = 1'b0;
      do_reset();
   endtask

   task automatic test_stray_ack();
      use_b = 1'b0;
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'hC3;
      repeat (4) @(negedge clk);
      checks++;
      if (en !== 1'b1 || cs !== 1'b0 || rdata !== rd_m[0] || err !== err_m[0]) begin
         errors++; $display("FAIL stray_ack: got en=%b cs=%b rdata=%h err=%b expected 1 0 %h %b", en, cs, rdata, err, rd_m[0], err_m[0]);
      end
      mem_ack = 1'b0;
      run_xfer(1'b0, 16'h0042, 8'h00, 2, 8'h96, 1'b0);
   endtask

   task automatic test_reset_mid_strobe();
      int n;
      use_b = 1'b0;
      run_xfer(1'b0, 16'h0BAD, 8'h00, 0, 8'h00, 1'b0);
      @(negedge clk); req = 1'b1; which = 1'b1; addr = 16'h4242; wdata = 8'h77;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk); req = 1'b0; n++;
      end while (cs !== 1'b1 && n < 50);
      checks++;
      if (cs !== 1'b1 || we !== 1'b1) begin errors++; $display("FAIL mid_pre: got cs=%b we=%b expected 1 1", cs, we); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (cs !== 1'b0 || we !== 1'b0 || en !== 1'b1) begin errors++; $display("FAIL mid_reset_strobe: got cs=%b we=%b en=%b expected 0 0 1", cs, we, en); end
      checks++;
      if (rdata !== '0 || err !== 1'b0 || maddr !== '0) begin errors++; $display("FAIL mid_reset_data: got rdata=%h err=%b addr=%h expected 0", rdata, err, maddr); end
      @(negedge clk); rst = 1'b0;
      rd_m[0] = '0; rd_m[1] = '0; err_m[0] = 1'b0; err_m[1] = 1'b0;
      run_xfer(1'b0, 16'h0001, 8'h00, 1, 8'h3D, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         use_b = 1'($urandom);
         run_xfer(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 20)),
                  DW'($urandom), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0) pulse_clr();
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; which = 1'b0; addr = '0; wdata = '0;
      mem_ack = 1'b0; err_clr = 1'b0; mem_rdata = '0; use_b = 1'b0;
      test_reset();
      test_read_ws2();
      test_write_ws0();
      test_timeout();
      test_back_to_back();
      test_stray_ack();
      test_reset_mid_strobe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors + 1);
      $fatal(1, "watchdog expired");
   end
endmodule
